store_write_combiner: RTL and testbench

STORE_WRITE_COMBINER -- requirements
Module: store_write_combiner

---
 rtl/store_write_combiner.sv | 142 ++++++++++++++
 tb/tb_store_write_combiner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_combiner.sv
// Single-entry store write combiner between the store buffer commit queue and the D$.
// Stores to the same 8-byte line are merged until timeout, a full line, a conflict or a drain.
module store_write_combiner #(
   parameter int ADDR_W  = 56,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              st_req_i,
   output logic              st_gnt_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [DATA_W-1:0] st_wdata_i,
   input  logic [DATA_W/8-1:0] st_be_i,
   input  logic [1:0]        st_size_i,
   input  logic              drain_i,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [1:0]        mem_size_o,
   input  logic [11:0]       page_offset_i,
   output logic              page_offset_matches_o,
   output logic              empty_o
);
   localparam int BE_W  = DATA_W / 8;
   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_e;

   state_e              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt, w_merge_data;
   logic [BE_W-1:0]     r_be, w_be_nxt;
   logic [1:0]          r_size, w_size_nxt;
   logic                r_merged, w_merged_nxt;
   logic [TMR_W-1:0]    r_tmr, w_tmr_nxt;
   logic                w_match, w_be_full, w_tmr_exp, w_cap;

   assign w_match   = (st_addr_i[ADDR_W-1:3] == r_addr[ADDR_W-1:3]);
   assign w_be_full = &r_be;
   // Expiry looks at the incremented value so the entry issues TIMEOUT cycles after capture.
   assign w_tmr_exp = (int'(r_tmr) + 1 >= TIMEOUT - 1);

   always_comb begin
      w_merge_data = r_wdata;
      for (int i = 0; i < BE_W; i++)
         if (st_be_i[i]) w_merge_data[i*8 +: 8] = st_wdata_i[i*8 +: 8];
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_be_nxt     = r_be;
      w_size_nxt   = r_size;
      w_merged_nxt = r_merged;
      w_tmr_nxt    = r_tmr;
      w_cap        = 1'b0;
      st_gnt_o     = 1'b0;
      mem_req_o    = 1'b0;
      case (r_state)
         IDLE: begin
            st_gnt_o = 1'b1;
            if (st_req_i) begin
               w_cap       = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (drain_i || w_be_full) begin
               w_state_nxt = ISSUE;
            end else begin
               st_gnt_o = w_match;
               if (st_req_i && w_match) begin
                  w_wdata_nxt  = w_merge_data;
                  w_be_nxt     = r_be | st_be_i;
                  w_merged_nxt = 1'b1;
                  w_tmr_nxt    = '0;
                  if (&(r_be | st_be_i)) w_state_nxt = ISSUE;
               end else if (st_req_i) begin
                  w_state_nxt = ISSUE;
               end else begin
                  w_tmr_nxt = r_tmr + TMR_W'(1);
                  if (w_tmr_exp) w_state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_req_o = 1'b1;
            st_gnt_o  = mem_gnt_i;
            if (mem_gnt_i) begin
               if (st_req_i) begin
                  w_cap       = 1'b1;
                  w_state_nxt = HOLD;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_cap) begin
         w_addr_nxt   = st_addr_i;
         w_wdata_nxt  = st_wdata_i;
         w_be_nxt     = st_be_i;
         w_size_nxt   = st_size_i;
         w_merged_nxt = 1'b0;
         w_tmr_nxt    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_size   <= '0;
         r_merged <= 1'b0;
         r_tmr    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_be     <= w_be_nxt;
         r_size   <= w_size_nxt;
         r_merged <= w_merged_nxt;
         r_tmr    <= w_tmr_nxt;
      end
   end

   // A merged entry covers the whole aligned doubleword.
   assign mem_addr_o  = r_merged ? {r_addr[ADDR_W-1:3], 3'b000} : r_addr;
   assign mem_size_o  = r_merged ? 2'b11 : r_size;
   assign mem_wdata_o = r_wdata;
   assign mem_be_o    = r_be;

   assign page_offset_matches_o = (r_state != IDLE) && (page_offset_i[11:3] == r_addr[11:3]);
   assign empty_o               = (r_state == IDLE);
endmodule

// File: tb/tb_store_write_combiner.sv
// Bench for store_write_combiner: directed vector table, reset-in-ISSUE sequence,
// then randomized traffic checked against a behavioural model.
module tb_store_write_combiner;
   localparam int ADDR_W = 56, DATA_W = 64, TIMEOUT = 8;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              st_req = 1'b0, st_gnt, drain = 1'b0, mem_req, mem_gnt = 1'b0;
   logic [ADDR_W-1:0] st_addr = '0, mem_addr;
   logic [DATA_W-1:0] st_wdata = '0, mem_wdata;
   logic [7:0]        st_be = '0, mem_be;
   logic [1:0]        st_size = '0, mem_size;
   logic [11:0]       poff = '0;
   logic              pm, empty;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   store_write_combiner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .st_req_i(st_req), .st_gnt_o(st_gnt), .st_addr_i(st_addr), .st_wdata_i(st_wdata),
      .st_be_i(st_be), .st_size_i(st_size), .drain_i(drain),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_be_o(mem_be), .mem_size_o(mem_size),
      .page_offset_i(poff), .page_offset_matches_o(pm), .empty_o(empty));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one held entry, either waiting or being issued.
   bit          m_val, m_iss, m_mrg;
   logic [55:0] m_a;
   logic [63:0] m_d;
   logic [7:0]  m_be;
   logic [1:0]  m_sz;
   int          m_age;

   function automatic void m_reset();
      m_val = 0; m_iss = 0; m_mrg = 0; m_a = '0; m_d = '0; m_be = '0; m_sz = '0; m_age = 0;
   endfunction

   function automatic void m_capture();
      m_val = 1; m_iss = 0; m_mrg = 0; m_age = 0;
      m_a = st_addr; m_d = st_wdata; m_be = st_be; m_sz = st_size;
   endfunction

   function automatic bit m_hit();
      return (st_addr >> 3) == (m_a >> 3);
   endfunction

   function automatic void m_step();
      if (!m_val) begin
         if (st_req) m_capture();
      end else if (m_iss) begin
         if (mem_gnt) begin
            if (st_req) m_capture();
            else m_val = 0;
         end
      end else if (drain || m_be == 8'hFF) begin
         m_iss = 1;
      end else if (st_req && m_hit()) begin
         for (int b = 0; b < 8; b++) if (st_be[b]) m_d[b*8 +: 8] = st_wdata[b*8 +: 8];
         m_be = m_be | st_be; m_mrg = 1; m_age = 0;
         if (m_be == 8'hFF) m_iss = 1;
      end else if (st_req) begin
         m_iss = 1;
      end else begin
         m_age++;
         if (m_age >= TIMEOUT - 1) m_iss = 1;
      end
   endfunction

   task automatic m_check();
      logic eg;
      eg = !m_val ? 1'b1 : m_iss ? mem_gnt : (!drain && m_be != 8'hFF && m_hit());
      chk("m_empty", empty, !m_val);
      chk("m_mem_req", mem_req, m_val && m_iss);
      chk("m_pm", pm, m_val && (poff[11:3] == m_a[11:3]));
      if (st_req) chk("m_st_gnt", st_gnt, eg);
      if (m_val && m_iss) begin
         chk("m_mem_addr", mem_addr, m_mrg ? (m_a & ~56'h7) : m_a);
         chk("m_mem_wdata", mem_wdata, m_d);
         chk("m_mem_be", mem_be, m_be);
         chk("m_mem_size", mem_size, m_mrg ? 2'd3 : m_sz);
      end
   endtask

   task automatic drive(input logic req, input logic [55:0] a, input logic [7:0] be,
                        input logic [1:0] sz, input logic dr, input logic mg, input logic [11:0] po);
      @(negedge clk);
      st_req = req; st_addr = a; st_wdata = {$urandom, $urandom}; st_be = be; st_size = sz;
      drain = dr; mem_gnt = mg; poff = po;
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      m_step();
   endtask

   typedef struct {
      logic req; logic [55:0] a; logic [7:0] be; logic [1:0] sz; logic dr; logic mg; logic [11:0] po;
      logic eg; logic em; logic ee; logic ep; logic [55:0] ea; logic [7:0] eb; logic [1:0] es;
   } vec_t;
   vec_t tbl[$];

   function automatic void v(logic req, logic [55:0] a, logic [7:0] be, logic [1:0] sz, logic dr,
                             logic mg, logic [11:0] po, logic eg, logic em, logic ee, logic ep,
                             logic [55:0] ea, logic [7:0] eb, logic [1:0] es);
      vec_t t;
      t.req = req; t.a = a; t.be = be; t.sz = sz; t.dr = dr; t.mg = mg; t.po = po;
      t.eg = eg; t.em = em; t.ee = ee; t.ep = ep; t.ea = ea; t.eb = eb; t.es = es;
      tbl.push_back(t);
   endfunction

   function automatic void hold_idle(int n, logic [11:0] po, logic ep);
      for (int i = 0; i < n; i++) v(0, 0, 0, 0, 0, 0, po, 0, 0, 0, ep, 0, 0, 0);
   endfunction

   initial begin
      m_reset();
      // Single store issues on timeout
      v(1, 'h1000, 'h0F, 2, 0, 0, 'h800, 1, 0, 1, 0, 0, 0, 0);
      hold_idle(TIMEOUT - 1, 'h800, 0);
      v(0, 0, 0, 0, 0, 1, 'h800, 0, 1, 0, 0, 'h1000, 'h0F, 2);
      // Two halves merge into one full doubleword
      v(1, 'h1000, 'h0F, 2, 0, 0, 'h000, 1, 0, 1, 0, 0, 0, 0);
      v(1, 'h1004, 'hF0, 2, 0, 0, 'h000, 1, 0, 0, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 1, 'h000, 0, 1, 0, 1, 'h1000, 'hFF, 3);
      // Conflicting line: stall, issue, zero-bubble handoff
      v(1, 'h1000, 'h0F, 2, 0, 0, 'h800, 1, 0, 1, 0, 0, 0, 0);
      v(1, 'h2000, 'h0F, 2, 0, 0, 'h800, 0, 0, 0, 0, 0, 0, 0);
      v(1, 'h2000, 'h0F, 2, 0, 0, 'h800, 0, 1, 0, 0, 'h1000, 'h0F, 2);
      v(1, 'h2000, 'h0F, 2, 0, 1, 'h800, 1, 1, 0, 0, 'h1000, 'h0F, 2);
      v(0, 0, 0, 0, 0, 0, 'h000, 0, 0, 0, 1, 0, 0, 0);
      v(0, 0, 0, 0, 1, 0, 'h800, 0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 1, 'h800, 0, 1, 0, 0, 'h2000, 'h0F, 2);
      // Drain ignored in IDLE; drain beats a matching store in HOLD
      v(1, 'h1000, 'h0F, 2, 1, 0, 'h800, 1, 0, 1, 0, 0, 0, 0);
      v(1, 'h1004, 'hF0, 2, 1, 0, 'h800, 0, 0, 0, 0, 0, 0, 0);
      v(1, 'h1004, 'hF0, 2, 0, 1, 'h800, 1, 1, 0, 0, 'h1000, 'h0F, 2);
      v(0, 0, 0, 0, 1, 0, 'h800, 0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 1, 'h800, 0, 1, 0, 0, 'h1004, 'hF0, 2);
      // Page offset hazard compare
      v(1, 'h1238, 'h01, 0, 0, 0, 'h23C, 1, 0, 1, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 'h23C, 0, 0, 0, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 'h240, 0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 0, 1, 0, 'h23C, 0, 0, 0, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 1, 'h238, 0, 1, 0, 1, 'h1238, 'h01, 0);
      v(0, 0, 0, 0, 0, 0, 'h238, 0, 0, 1, 0, 0, 0, 0);
      // Zero-byte stores, merge coinciding with expiry, merged address alignment
      v(1, 'h300C, 'h00, 1, 0, 0, 'h800, 1, 0, 1, 0, 0, 0, 0);
      hold_idle(TIMEOUT - 2, 'h800, 0);
      v(1, 'h3008, 'h00, 3, 0, 0, 'h800, 1, 0, 0, 0, 0, 0, 0);
      hold_idle(TIMEOUT - 1, 'h800, 0);
      v(0, 0, 0, 0, 0, 0, 'h800, 0, 1, 0, 0, 'h3008, 'h00, 3);
      v(0, 0, 0, 0, 0, 1, 'h800, 0, 1, 0, 0, 'h3008, 'h00, 3);
      v(0, 0, 0, 0, 0, 0, 'h800, 0, 0, 1, 0, 0, 0, 0);
      // Full byte enables on capture force issue
      v(1, 'h4000, 'hFF, 3, 0, 0, 'h800, 1, 0, 1, 0, 0, 0, 0);
      v(1, 'h4000, 'h01, 0, 0, 0, 'h800, 0, 0, 0, 0, 0, 0, 0);
      v(1, 'h4000, 'h01, 0, 0, 1, 'h800, 1, 1, 0, 0, 'h4000, 'hFF, 3);
      v(0, 0, 0, 0, 1, 0, 'h800, 0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 1, 'h800, 0, 1, 0, 0, 'h4000, 'h01, 0);

      // Reset state
      #2;
      chk("rst_empty", empty, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_st_gnt", st_gnt, 1);
      chk("rst_pm", pm, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      @(negedge clk); rst_n = 1'b1;

      foreach (tbl[k]) begin
         drive(tbl[k].req, tbl[k].a, tbl[k].be, tbl[k].sz, tbl[k].dr, tbl[k].mg, tbl[k].po);
         chk($sformatf("v%0d_empty", k), empty, tbl[k].ee);
         chk($sformatf("v%0d_mem_req", k), mem_req, tbl[k].em);
         chk($sformatf("v%0d_pm", k), pm, tbl[k].ep);
         if (tbl[k].req) chk($sformatf("v%0d_st_gnt", k), st_gnt, tbl[k].eg);
         if (tbl[k].em) begin
            chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].ea);
            chk($sformatf("v%0d_mem_be", k), mem_be, tbl[k].eb);
            chk($sformatf("v%0d_mem_size", k), mem_size, tbl[k].es);
         end
         advance();
      end

      // Reset while an issue is pending
      drive(1, 'h1000, 'h0F, 2, 0, 0, 'h000); advance();
      drive(0, 0, 0, 0, 1, 0, 'h000); advance();
      drive(0, 0, 0, 0, 0, 0, 'h000);
      chk("ri_mem_req_before", mem_req, 1);
      rst_n = 1'b0; #1;
      m_reset();
      chk("ri_mem_req", mem_req, 0);
      chk("ri_empty", empty, 1);
      chk("ri_st_gnt", st_gnt, 1);
      chk("ri_pm", pm, 0);
      chk("ri_mem_addr", mem_addr, 0);
      chk("ri_mem_wdata", mem_wdata, 0);
      chk("ri_mem_size", mem_size, 0);
      @(posedge clk); @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(0, 0, 0, 0, 0, i[0], 'h000);
         chk("ri_after_mem_req", mem_req, 0);
         chk("ri_after_empty", empty, 1);
         advance();
      end

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [55:0] a;
         logic [7:0]  be;
         logic [11:0] po;
         int          r;
         case ($urandom_range(0, 3))
            0: a = 56'h1000; 1: a = 56'h1008; 2: a = 56'h2000; default: a = 56'hABC_D000;
         endcase
         a = a + 56'($urandom_range(0, 7));
         r = $urandom_range(0, 9);
         be = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
         po = $urandom_range(0, 1) ? a[11:0] : 12'($urandom);
         drive($urandom_range(0, 9) < 6, a, be, 2'($urandom), $urandom_range(0, 11) == 0,
               $urandom_range(0, 1) == 1, po);
         m_check();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
